// File: rtl/sm_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : sm_sub_serial
// Description : Bit-serial sign-magnitude subtractor computing
//               (sign_a,a) - (sign_b,b). The magnitude is formed one bit per
//               cycle, LSB first. A borrow out of the subtract path is
//               corrected by a second serial pass that two's-complements the
//               partial result.
//               Build option: define SM_SUB_OVF_SAT_EN to saturate mag_diff
//               to all ones on overflow. When it is undefined, mag_diff
//               carries the wrapped low N bits. overflow is flagged in both
//               builds.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_sub_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sign_a,
    input  logic         sign_b,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         sign_diff,
    output logic [N-1:0] mag_diff,
    output logic         overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_res;
    logic           r_sign_a;
    logic           r_sign_b;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;

    logic           w_add;
    logic           w_last;
    logic           w_bit;
    logic           w_carry_nxt;
    logic [N-1:0]   w_res_nxt;
    logic           w_load;
    logic           w_to_fix;
    logic           w_sign_out;
    logic           w_ovf_out;
    logic [N-1:0]   w_mag_out;

    // The subtrahend's effective sign is inverted. Equal signs mean the
    // magnitudes are added.
    assign w_add  = (r_sign_a == ~r_sign_b);
    assign w_last = (r_cnt == C_LAST);

    // One serial bit step: full-add, full-subtract, or the two's-complement
    // correction pass (invert and add the carry seeded with 1).
    always_comb begin
        w_bit       = 1'b0;
        w_carry_nxt = r_carry;
        w_res_nxt   = r_res >> 1;
        case (r_state)
            CALC: begin
                w_bit = r_a[0] ^ r_b[0] ^ r_carry;
                if (w_add) begin
                    w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
                end else begin
                    w_carry_nxt = (~r_a[0] & r_b[0]) | (r_carry & ~(r_a[0] ^ r_b[0]));
                end
            end
            FIX: begin
                w_bit       = ~r_res[0] ^ r_carry;
                w_carry_nxt = ~r_res[0] & r_carry;
            end
            default: ;
        endcase
        w_res_nxt[N-1] = w_bit;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, status outputs and the result to load on DONE entry.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        w_load      = 1'b0;
        w_to_fix    = 1'b0;
        w_sign_out  = r_sign_a;
        w_ovf_out   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    if (w_add || !w_carry_nxt) begin
                        w_state_nxt = DONE;
                        w_load      = 1'b1;
                        w_ovf_out   = w_add & w_carry_nxt;
                    end else begin
                        w_state_nxt = FIX;
                        w_to_fix    = 1'b1;
                    end
                end
            end
            FIX: begin
                w_sign_out = ~r_sign_a;
                if (w_last) begin
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
`ifdef SM_SUB_OVF_SAT_EN
        w_mag_out = w_ovf_out ? {N{1'b1}} : w_res_nxt;
`else
        w_mag_out = w_res_nxt;
`endif
        // A true zero is always reported as positive.
        if ((w_mag_out == '0) && !w_ovf_out) begin
            w_sign_out = 1'b0;
        end
    end

    // Operand capture, shift registers, carry/borrow and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_sign_a <= sign_a;
                        r_sign_b <= sign_b;
                        r_res    <= '0;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_nxt;
                    // Entering FIX seeds the "+1" of the two's complement.
                    r_carry <= w_to_fix ? 1'b1 : w_carry_nxt;
                    r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                end
                FIX: begin
                    r_res   <= w_res_nxt;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers are loaded once per operation on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_diff <= 1'b0;
            mag_diff  <= '0;
            overflow  <= 1'b0;
        end else if (w_load) begin
            sign_diff <= w_sign_out;
            mag_diff  <= w_mag_out;
            overflow  <= w_ovf_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_sub_serial
// Description : Directed self-checking bench for sm_sub_serial (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_sub_serial;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sign_a;
    logic         sign_b;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         sign_diff;
    logic [N-1:0] mag_diff;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    sm_sub_serial #(.N(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sign_diff (sign_diff),
        .mag_diff  (mag_diff),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, result, the single-cycle done
    // pulse, and that a start raised during DONE is ignored.
    task automatic run_op(input string tag,
                          input logic sa, input logic [N-1:0] ma,
                          input logic sb, input logic [N-1:0] mb,
                          input logic es, input logic [N-1:0] em,
                          input logic eo, input int elat,
                          input bit poke);
        int c;
        @(negedge clk);
        start = 1'b1; sign_a = sa; a = ma; sign_b = sb; b = mb;
        @(posedge clk);
        #1;
        start = 1'b0; sign_a = ~sa; a = ~ma; sign_b = ~sb; b = ~mb;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) check_eq({tag, " busy"}, int'(busy), 1);
            if (poke && c == 2) begin
                start = 1'b1; sign_a = 1'b0; a = 4'd15; sign_b = 1'b1; b = 4'd15;
            end else begin
                start = 1'b0;
            end
        end while (!done && c < 40);
        start = 1'b0;
        check_eq({tag, " latency"}, c, elat);
        check_eq({tag, " sign_diff"}, int'(sign_diff), int'(es));
        check_eq({tag, " mag_diff"}, int'(mag_diff), int'(em));
        check_eq({tag, " overflow"}, int'(overflow), int'(eo));
        // start during DONE must not launch a new operation
        start = 1'b1; sign_a = 1'b1; a = 4'd9; sign_b = 1'b0; b = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, " done pulse"}, int'(done), 0);
        check_eq({tag, " idle after"}, int'(busy), 0);
        check_eq({tag, " hold mag"}, int'(mag_diff), int'(em));
    endtask

    initial begin
        logic [N-1:0] ovf_mag;
        rst_n = 1'b0; start = 1'b0; sign_a = 1'b0; sign_b = 1'b0; a = '0; b = '0;
        @(negedge clk);
        check_eq("reset busy", int'(busy), 0);
        check_eq("reset done", int'(done), 0);
        check_eq("reset sign", int'(sign_diff), 0);
        check_eq("reset mag", int'(mag_diff), 0);
        check_eq("reset ovf", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // (+10)-(-2): add path
        run_op("p10_m_m2", 1'b0, 4'd10, 1'b1, 4'd2, 1'b0, 4'd12, 1'b0, 5, 1'b0);
        // (-9)-(-5): subtract, no borrow
        run_op("m9_m_m5", 1'b1, 4'd9, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 5, 1'b0);
        // (+7)-(+6), with a start pulse while busy
        run_op("p7_m_p6", 1'b0, 4'd7, 1'b0, 4'd6, 1'b0, 4'd1, 1'b0, 5, 1'b1);
        // (-0)-(-9): borrow, FIX path
        run_op("m0_m_m9", 1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 9, 1'b0);
        // (+5)-(+5): zero result
        run_op("p5_m_p5", 1'b0, 4'd5, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 5, 1'b0);
        // (+3)-(+5): FIX path, negative result
        run_op("p3_m_p5", 1'b0, 4'd3, 1'b0, 4'd5, 1'b1, 4'd2, 1'b0, 9, 1'b0);
        // (-0)-(+0): negative zero in, positive zero out
        run_op("m0_m_p0", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5, 1'b0);
        // (+10)-(-8): overflow
`ifdef SM_SUB_OVF_SAT_EN
        ovf_mag = 4'd15;
`else
        ovf_mag = 4'd2;
`endif
        run_op("p10_m_m8", 1'b0, 4'd10, 1'b1, 4'd8, 1'b0, ovf_mag, 1'b1, 5, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; sign_a = 1'b0; a = 4'd3; sign_b = 1'b0; b = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; sign_a = 1'b1; a = 4'd4; sign_b = 1'b0; b = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("rst busy before", int'(busy), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst busy", int'(busy), 0);
        check_eq("rst done", int'(done), 0);
        check_eq("rst sign", int'(sign_diff), 0);
        check_eq("rst mag", int'(mag_diff), 0);
        check_eq("rst ovf", int'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("rst no done", int'(done), 0);
        end
        rst_n = 1'b1;
        // (-1)-(+2) right after release
        run_op("m1_m_p2", 1'b1, 4'd1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b0, 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm_sub_serial.md
SM_SUB_SERIAL -- requirements
Module: sm_sub_serial

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand and result magnitude width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to compute (sign_a,a) - (sign_b,b); sampled only in IDLE.
REQ-005 SHALL have ports sign_a and sign_b, inputs, 1 bit each: operand signs, 1 = negative.
REQ-006 SHALL have ports a and b, inputs, N bits each: operand magnitudes.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have ports sign_diff (output, 1 bit) and mag_diff (output, N bits): registered sign-magnitude result.
REQ-010 SHALL have port overflow, output, 1 bit: magnitude of the true result exceeds 2^N-1.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-012 IDLE with start=1 SHALL capture all four operands, clear the bit counter and carry/borrow, and enter CALC.
REQ-013 SHALL form the effective subtrahend sign eb = ~sign_b; the add path applies when sign_a == eb, otherwise the subtract path applies.
REQ-014 CALC SHALL process one bit per cycle, LSB first, for exactly N cycles.
REQ-015 CALC SHALL perform a full-add with carry on the add path, or a full-subtract a-b with borrow on the subtract path.
REQ-016 After CALC, the add path SHALL go to DONE with sign = sign_a and overflow = final carry.
REQ-017 After CALC, the subtract path with final borrow = 0 SHALL go to DONE with sign = sign_a and overflow = 0.
REQ-018 After CALC, the subtract path with final borrow = 1 SHALL go to FIX.
REQ-019 FIX SHALL two's-complement the partial result serially in N cycles, set sign = ~sign_a and overflow = 0, then go to DONE.
REQ-020 DONE SHALL last one cycle with done=1, update sign_diff, mag_diff and overflow in that cycle, then return to IDLE.
REQ-021 Latency SHALL be N+1 cycles from the start-sampling edge to done on the add and no-borrow paths, and 2N+1 cycles on the FIX path.
REQ-022 A zero result magnitude SHALL force sign_diff=0 (no negative zero); negative-zero inputs SHALL be treated as zero.
REQ-023 start while busy=1 SHALL be ignored, and outputs SHALL hold their last values until the next DONE.
REQ-024 start=1 in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and busy=0, done=0, sign_diff=0, mag_diff=0, overflow=0, and clear the counter and carry.
REQ-026 Reset asserted mid-operation SHALL abort the operation without producing a done pulse.
REQ-027 After reset release, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SM_SUB_OVF_SAT_EN SHALL select the overflow behaviour.
REQ-029 With SM_SUB_OVF_SAT_EN defined, a DONE with overflow=1 SHALL load mag_diff with all ones (2^N-1).
REQ-030 Without SM_SUB_OVF_SAT_EN, a DONE with overflow=1 SHALL load mag_diff with the wrapped low N bits; overflow SHALL be flagged in both builds.

Verification (N=4)
REQ-031 (+10)-(-2): add path -> done 5 cycles after start, sign_diff=0, mag_diff=12, overflow=0.
REQ-032 (-9)-(-5): subtract path, no borrow -> done after 5 cycles, sign_diff=1, mag_diff=4; (+7)-(+6) -> sign_diff=0, mag_diff=1.
REQ-033 (-0)-(-9): FIX path -> done after 9 cycles, sign_diff=0, mag_diff=9; (+5)-(+5) -> sign_diff=0, mag_diff=0.
REQ-034 (+10)-(-8): overflow=1, mag_diff=15 with SM_SUB_OVF_SAT_EN defined and mag_diff=2 without it.
REQ-035 Apply start, pulse start again 2 cycles later, then assert rst_n=0 at cycle 3 -> all outputs 0, no done; a fresh (-1)-(+2) after release -> sign_diff=1, mag_diff=3.
